// File: rtl/serial_adc_pkg.sv
// Shared types and width helpers for the serial ADC receiver.
// Holds the frame state encoding and the channel/command width calculations.
package serial_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic int ch_w_f(input int ch_n);
        return $clog2(ch_n);
    endfunction

    // Command frame is one start bit followed by the channel index.
    function automatic int cmd_w_f(input int ch_n);
        return 32'sd1 + ch_w_f(ch_n);
    endfunction

endpackage

// File: rtl/serial_shift_in.sv
// Serial-to-parallel shift register, MSB first, with synchronous clear and enable.
// A clear overrides a shift in the same cycle.
module serial_shift_in #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              din,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;

    // Next value of the shift register.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = {q_q[DATA_W-2:0], din};
        end else begin
            q_d = q_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/serial_adc_rx.sv
// Serial ADC receiver: sends a start bit plus channel index, then shifts in one sample.
// All outputs are registered and computed from the next-state values.
module serial_adc_rx
    import serial_adc_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int CH_N   = 4,
    parameter int SCAN   = 0,
    localparam int CH_W  = ch_w_f(CH_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              in_bit,
    output logic              out_bit,
    output logic              cs_n,
    output logic              busy,
    output logic [DATA_W-1:0] num,
    output logic [CH_W-1:0]   num_ch,
    output logic              valid
);

    localparam int CMD_W = cmd_w_f(CH_N);
    localparam int MAX_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CH_W-1:0]   cmd_q, cmd_d;
    logic [CH_W-1:0]   scan_q, scan_d;
    logic [CH_W-1:0]   num_ch_q, num_ch_d;
    logic [DATA_W-1:0] num_q, num_d;
    logic              out_bit_q, out_bit_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [CH_W-1:0]   sel_s;
    logic [DATA_W-1:0] shift_s;
    logic              shift_clr_s;
    logic              shift_en_s;

    serial_shift_in #(.DATA_W(DATA_W)) u_shift (
        .clk (clk),
        .rst (rst),
        .clr (shift_clr_s),
        .en  (shift_en_s),
        .din (in_bit),
        .q   (shift_s)
    );

    // Channel chosen for a new frame; out-of-range requests fall back to channel 0.
    always_comb begin
        sel_s = '0;
        if (SCAN != 0) begin
            sel_s = scan_q;
        end else if (int'(ch_sel) < CH_N) begin
            sel_s = ch_sel;
        end else begin
            sel_s = '0;
        end
    end

    // Next-state, counter, command shifter and output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        ch_d        = ch_q;
        cmd_d       = cmd_q;
        scan_d      = scan_q;
        num_d       = num_q;
        num_ch_d    = num_ch_q;
        out_bit_d   = 1'b0;
        valid_d     = 1'b0;
        shift_clr_s = 1'b0;
        shift_en_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d     = ST_CMD;
                    ch_d        = sel_s;
                    cmd_d       = sel_s;
                    out_bit_d   = 1'b1;
                    shift_clr_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (cnt_q == CNT_W'(CMD_W - 1)) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    // The start bit is already on the wire; feed channel bits MSB first.
                    out_bit_d = cmd_q[CH_W-1];
                    cmd_d     = cmd_q << 1'b1;
                end
            end
            ST_SAMPLE: begin
                shift_en_s = 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                num_d    = shift_s;
                num_ch_d = ch_q;
                valid_d  = 1'b1;
                if (SCAN != 0) begin
                    if (scan_q == CH_W'(CH_N - 1)) begin
                        scan_d = '0;
                    end else begin
                        scan_d = scan_q + CH_W'(1);
                    end
                end else begin
                    scan_d = scan_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        cs_n_d = !((state_d == ST_CMD) || (state_d == ST_SAMPLE));
        busy_d = (state_d != ST_IDLE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            cmd_q     <= '0;
            scan_q    <= '0;
            num_q     <= '0;
            num_ch_q  <= '0;
            out_bit_q <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            cmd_q     <= cmd_d;
            scan_q    <= scan_d;
            num_q     <= num_d;
            num_ch_q  <= num_ch_d;
            out_bit_q <= out_bit_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    assign out_bit = out_bit_q;
    assign cs_n    = cs_n_q;
    assign busy    = busy_q;
    assign num     = num_q;
    assign num_ch  = num_ch_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_serial_adc_rx.sv
// Self-checking bench for serial_adc_rx across four parameter sets.
// Expected frames come from a cycle-offset model of the frame timeline.
module tb_serial_adc_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_bit;
    logic [3:0] st_v;
    logic [2:0] ch_sel;

    always #5 clk = ~clk;

    logic        ob0, cs0, bz0, vl0;
    logic [11:0] nm0;
    logic [1:0]  nc0;
    logic        ob1, cs1, bz1, vl1;
    logic [11:0] nm1;
    logic [1:0]  nc1;
    logic        ob2, cs2, bz2, vl2;
    logic [15:0] nm2;
    logic [2:0]  nc2;
    logic        ob3, cs3, bz3, vl3;
    logic [11:0] nm3;
    logic [2:0]  nc3;

    serial_adc_rx #(.DATA_W(12), .CH_N(4), .SCAN(0)) u0 (
        .clk(clk), .rst(rst), .start(st_v[0]), .ch_sel(ch_sel[1:0]), .in_bit(in_bit),
        .out_bit(ob0), .cs_n(cs0), .busy(bz0), .num(nm0), .num_ch(nc0), .valid(vl0));
    serial_adc_rx #(.DATA_W(12), .CH_N(4), .SCAN(1)) u1 (
        .clk(clk), .rst(rst), .start(st_v[1]), .ch_sel(ch_sel[1:0]), .in_bit(in_bit),
        .out_bit(ob1), .cs_n(cs1), .busy(bz1), .num(nm1), .num_ch(nc1), .valid(vl1));
    serial_adc_rx #(.DATA_W(16), .CH_N(8), .SCAN(0)) u2 (
        .clk(clk), .rst(rst), .start(st_v[2]), .ch_sel(ch_sel), .in_bit(in_bit),
        .out_bit(ob2), .cs_n(cs2), .busy(bz2), .num(nm2), .num_ch(nc2), .valid(vl2));
    serial_adc_rx #(.DATA_W(12), .CH_N(6), .SCAN(0)) u3 (
        .clk(clk), .rst(rst), .start(st_v[3]), .ch_sel(ch_sel), .in_bit(in_bit),
        .out_bit(ob3), .cs_n(cs3), .busy(bz3), .num(nm3), .num_ch(nc3), .valid(vl3));

    logic        ob_a[4], cs_a[4], bz_a[4], vl_a[4];
    logic [15:0] nm_a[4];
    logic [2:0]  nc_a[4];

    assign ob_a[0] = ob0; assign cs_a[0] = cs0; assign bz_a[0] = bz0; assign vl_a[0] = vl0;
    assign ob_a[1] = ob1; assign cs_a[1] = cs1; assign bz_a[1] = bz1; assign vl_a[1] = vl1;
    assign ob_a[2] = ob2; assign cs_a[2] = cs2; assign bz_a[2] = bz2; assign vl_a[2] = vl2;
    assign ob_a[3] = ob3; assign cs_a[3] = cs3; assign bz_a[3] = bz3; assign vl_a[3] = vl3;
    assign nm_a[0] = {4'b0, nm0}; assign nc_a[0] = {1'b0, nc0};
    assign nm_a[1] = {4'b0, nm1}; assign nc_a[1] = {1'b0, nc1};
    assign nm_a[2] = nm2;         assign nc_a[2] = nc2;
    assign nm_a[3] = {4'b0, nm3}; assign nc_a[3] = nc3;

    int dw_c[4]   = '{12, 12, 16, 12};
    int chn_c[4]  = '{4, 4, 8, 6};
    int scan_c[4] = '{0, 1, 0, 0};
    int last_num[4];
    int last_ch[4];
    int scan_ptr[4];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 4; i++) begin
            last_num[i] = 0;
            last_ch[i]  = 0;
            scan_ptr[i] = 0;
        end
    endtask

    task automatic chk_idle(input int u, input string why);
        chk($sformatf("u%0d %s cs_n", u, why), 32'(cs_a[u]), 32'd1);
        chk($sformatf("u%0d %s busy", u, why), 32'(bz_a[u]), 32'd0);
        chk($sformatf("u%0d %s valid", u, why), 32'(vl_a[u]), 32'd0);
        chk($sformatf("u%0d %s out_bit", u, why), 32'(ob_a[u]), 32'd0);
        chk($sformatf("u%0d %s num", u, why), 32'(nm_a[u]), 32'(last_num[u]));
        chk($sformatf("u%0d %s num_ch", u, why), 32'(nc_a[u]), 32'(last_ch[u]));
    endtask

    // Runs one frame on unit u, entered and left on a falling edge with the unit idle.
    // ign_k / rst_k give the frame cycle at which a stray start or a reset is applied (-1: none).
    task automatic frame(input int u, input int ch, input int data, input int ign_k, input int rst_k);
        int cw, dw, cmdw, lat, ech, j, eb;
        cw   = $clog2(chn_c[u]);
        dw   = dw_c[u];
        cmdw = cw + 1;
        lat  = cmdw + dw + 1;
        ech  = (scan_c[u] != 0) ? scan_ptr[u] : ((ch < chn_c[u]) ? ch : 0);
        ch_sel  = 3'(ch);
        in_bit  = 1'b0;
        st_v    = 4'b0;
        st_v[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            st_v = 4'b0;
            if (k == ign_k) st_v[u] = 1'b1;
            if (k == 0)         eb = 1;
            else if (k < cmdw)  eb = (ech >> (cw - k)) & 1;
            else                eb = 0;
            chk($sformatf("u%0d k%0d out_bit", u, k), 32'(ob_a[u]), 32'(eb));
            chk($sformatf("u%0d k%0d cs_n", u, k), 32'(cs_a[u]), (k < cmdw + dw) ? 32'd0 : 32'd1);
            chk($sformatf("u%0d k%0d busy", u, k), 32'(bz_a[u]), (k < lat) ? 32'd1 : 32'd0);
            chk($sformatf("u%0d k%0d valid", u, k), 32'(vl_a[u]), (k == lat) ? 32'd1 : 32'd0);
            if (k == 0) begin
                chk($sformatf("u%0d hold num", u), 32'(nm_a[u]), 32'(last_num[u]));
                chk($sformatf("u%0d hold num_ch", u), 32'(nc_a[u]), 32'(last_ch[u]));
            end
            if (k == lat) begin
                chk($sformatf("u%0d num", u), 32'(nm_a[u]), 32'(data));
                chk($sformatf("u%0d num_ch", u), 32'(nc_a[u]), 32'(ech));
                last_num[u] = data;
                last_ch[u]  = ech;
                scan_ptr[u] = (scan_ptr[u] + 1) % chn_c[u];
            end
            if (k == rst_k) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                clear_models();
                chk_idle(u, "abort");
                return;
            end
            j = k + 1 - (cmdw + 1);
            if (j >= 0 && j < dw) in_bit = 1'((data >> (dw - 1 - j)) & 1);
            else                  in_bit = 1'($urandom_range(1, 0));
        end
    endtask

    initial begin
        int u, d;
        rst    = 1'b1;
        st_v   = 4'b0;
        ch_sel = 3'd0;
        in_bit = 1'b0;
        clear_models();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk_idle(i, "reset");
        // Start raised together with reset must be dropped.
        st_v = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        st_v = 4'b0;
        rst  = 1'b0;
        for (int i = 0; i < 4; i++) chk_idle(i, "rst+start");

        frame(0, 2, 32'hA5C, -1, -1);
        for (int i = 0; i < 3; i++) frame(0, $urandom_range(3, 0), $urandom_range(32'hFFF, 0), -1, -1);

        for (int i = 0; i < 5; i++) frame(1, $urandom_range(3, 0), $urandom_range(32'hFFF, 0), -1, -1);

        frame(0, 1, $urandom_range(32'hFFF, 0), 5, -1);
        frame(0, 3, $urandom_range(32'hFFF, 0), -1, 8);
        frame(0, 3, $urandom_range(32'hFFF, 0), -1, -1);

        frame(2, $urandom_range(7, 0), 32'hFFFF, -1, -1);
        frame(2, $urandom_range(7, 0), 32'h0001, -1, -1);

        frame(3, 7, $urandom_range(32'hFFF, 0), -1, -1);
        frame(3, 5, $urandom_range(32'hFFF, 0), -1, -1);
        frame(3, 6, $urandom_range(32'hFFF, 0), -1, -1);

        for (int i = 0; i < 8; i++) begin
            u = $urandom_range(3, 0);
            d = (u == 2) ? $urandom_range(32'hFFFF, 0) : $urandom_range(32'hFFF, 0);
            frame(u, $urandom_range(7, 0), d, -1, -1);
        end

        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk_idle(i, "final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
